pingpong_sched: RTL and testbench
=================================

Name: pingpong_sched

Overview:
- Single-clock scheduler for the input ping-pong buffer.
- Watches the buffer's fill-complete flag and drives the buffer's bank-select level.
- Once the swapped-out bank is full, generates the linear read-address stream the convolution engine uses to consume it.
- Sits between the input DMA/stream, the ping-pong buffer and the conv PE array.
- Counts input beats dropped because the fill bank was already full while the reader was still busy.

Parameters:
DP, 1024, words per bank; one frame = DP reads.
AW, 16, read-address width; DP <= 2^AW required.
SETTLE_CYC, 2, idle cycles after each bank toggle before reads start (buffer clears its fill counter and fill flag); legal range 1..15.
DCW, 16, width of the dropped-beat counter.

Ports:
i_clk  in  1  single system clock, rising edge.
i_rst  in  1  asynchronous, active-high reset.
i_en  in  1  block enable; low freezes all state and counters.
i_fill_ready  in  1  buffer flag: fill bank holds DP entries (level).
i_din_vld  in  1  input-beat valid, observed only for drop accounting.
i_rd_stall  in  1  consumer back-pressure; holds the current address.
o_switch  out  1  bank-select level to buffer: 0 = fill bank0/read bank1, 1 = the reverse.
o_rd_addr  out  AW  read address to buffer.
o_rd_vld  out  1  o_rd_addr valid this cycle.
o_frame_start  out  1  one-cycle pulse on the first read of a frame.
o_frame_done  out  1  one-cycle pulse on the cycle after the last read is accepted.
o_busy  out  1  high in SETTLE and READ.
o_drop_cnt  out  DCW  saturating count of dropped input beats.

Behaviour:
Reset (async, i_rst=1):
- State = WAIT_FILL.
- o_switch=0, o_rd_addr=0.
- o_rd_vld, o_frame_start, o_frame_done, o_busy = 0.
- o_drop_cnt=0, settle counter=0.
- All outputs are registered.

Reset mid-operation:
- Immediately aborts READ/SETTLE.
- o_switch returns to 0 even if it was 1.
- No o_frame_done is emitted.

State machine (advances only when i_en=1):
- WAIT_FILL:
  - Reader idle, o_rd_vld=0.
  - On i_fill_ready=1: toggle o_switch (next cycle), load settle counter with SETTLE_CYC, go to SETTLE.
- SETTLE:
  - o_busy=1, o_rd_vld=0.
  - Decrement each cycle; at 0 go to READ with o_rd_addr=0, o_rd_vld=1, o_frame_start=1.
- READ:
  - o_rd_vld=1.
  - Accept = o_rd_vld & ~i_rd_stall.
  - On accept with addr < DP-1: addr+1 next cycle.
  - On accept with addr = DP-1: next cycle o_rd_vld=0, o_frame_done=1, o_rd_addr=0, state WAIT_FILL.
  - While i_rd_stall=1: address and o_rd_vld held, no advance.
- A frame is exactly DP accepted reads (addresses 0..DP-1), no gaps other than stalls.
- Read latency: the read address presented in cycle N yields data from the buffer on its output clock edge; data alignment is the consumer's job.

Switch rules:
- o_switch toggles only on the WAIT_FILL→SETTLE transition, so it never toggles during READ.
- i_fill_ready sampled during SETTLE or READ is ignored, not latched. It is still high in WAIT_FILL if the fill completed earlier.
- If i_fill_ready=1 in the same cycle READ accepts its last address, the switch happens one cycle later from WAIT_FILL (2-cycle min gap between frames plus SETTLE_CYC).

Drop accounting:
- Each cycle with i_en & i_din_vld & i_fill_ready & state≠WAIT_FILL increments o_drop_cnt.
- Saturates at 2^DCW-1, no wrap.
- Beats in WAIT_FILL are not counted, since the switch is imminent.

i_en=0:
- State, address, settle counter and o_drop_cnt frozen.
- o_rd_vld, o_frame_start, o_frame_done forced 0.
- Resumes exactly where frozen.
- i_en=0 with i_fill_ready=1 does not switch.

Width rules:
- Address compare uses DP-1 cast to AW bits.
- Settle counter is 4 bits.
- Drop counter increment is saturating, DCW bits.

Decomposition:
- Shared package pingpong_pkg holds:
  - state encoding (WAIT_FILL=2'd0, SETTLE=2'd1, READ=2'd2);
  - DP default 1024 and AW default 16;
  - SETTLE_CYC default.
- One sub-module, pp_rd_addr_gen, contains:
  - AW-bit address counter with clear, stall-hold and last-address compare;
  - outputs addr and last.
- FSM, switch register and drop counter stay in pingpong_sched.

Test Plan:
1. Reset release, i_fill_ready=0 for 50 cycles -> o_switch=0, o_rd_vld=0, o_busy=0, o_drop_cnt=0 throughout.
2. DP=8, SETTLE_CYC=2, i_fill_ready pulse high 1 cycle -> o_switch 0→1 next cycle, two idle cycles, then o_rd_addr 0..7 on 8 consecutive cycles, o_frame_start with addr 0, o_frame_done one cycle after addr 7, o_switch stays 1.
3. DP=8, i_rd_stall high for 3 cycles while o_rd_addr=4 -> addr 4 held with o_rd_vld=1 for 4 cycles total; frame still ends after exactly 8 accepts.
4. DP=8, i_fill_ready held high and i_din_vld=1 for the whole READ -> o_drop_cnt=8 at frame end; second switch (1→0) occurs 1 cycle after o_frame_done.
5. DCW=4, force 20 drop cycles -> o_drop_cnt saturates at 15.
6. Assert i_rst at o_rd_addr=5 with o_switch=1 -> same-cycle (async) o_switch=0, o_rd_vld=0, no o_frame_done; after release, behaviour matches scenario 2.
7. i_en=0 at o_rd_addr=3 for 10 cycles -> addr held at 3, o_rd_vld=0; re-enable resumes at 3 and completes the frame.

Source files
------------

// File: rtl/pingpong_pkg.sv
// -----------------------------------------------------------------------------
// pingpong_pkg
// Shared definitions for the ping-pong buffer scheduler: FSM state encoding,
// default bank depth, read-address width, settle length and drop-counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package pingpong_pkg;

   typedef enum logic [1:0] {
      WAIT_FILL = 2'd0,
      SETTLE    = 2'd1,
      READ      = 2'd2
   } state_t;

   localparam int DP_DEF         = 1024;  // words per bank
   localparam int AW_DEF         = 16;    // read-address width
   localparam int SETTLE_CYC_DEF = 2;     // idle cycles after a bank toggle
   localparam int DCW_DEF        = 16;    // dropped-beat counter width
   localparam int SCW            = 4;     // settle counter width

endpackage

// File: rtl/pingpong_sched_if.sv
// -----------------------------------------------------------------------------
// pingpong_sched_if
// Bundles the scheduler's control inputs and buffer/consumer-facing outputs.
//   i_en          block enable
//   i_fill_ready  fill bank holds a full frame (level)
//   i_din_vld     input beat valid (drop accounting only)
//   i_rd_stall    consumer back-pressure
//   o_switch      bank-select level
//   o_rd_addr     read address, o_rd_vld qualifies it
//   o_frame_start / o_frame_done  frame boundary pulses
//   o_busy        scheduler settling or reading
//   o_drop_cnt    saturating dropped-beat count
// Modport master is the scheduler, modport slave is its environment.
// -----------------------------------------------------------------------------
interface pingpong_sched_if #(
   parameter int AW  = 16,
   parameter int DCW = 16
);
   logic           i_en;
   logic           i_fill_ready;
   logic           i_din_vld;
   logic           i_rd_stall;
   logic           o_switch;
   logic [AW-1:0]  o_rd_addr;
   logic           o_rd_vld;
   logic           o_frame_start;
   logic           o_frame_done;
   logic           o_busy;
   logic [DCW-1:0] o_drop_cnt;

   modport master (
      input  i_en, i_fill_ready, i_din_vld, i_rd_stall,
      output o_switch, o_rd_addr, o_rd_vld, o_frame_start, o_frame_done,
             o_busy, o_drop_cnt
   );

   modport slave (
      output i_en, i_fill_ready, i_din_vld, i_rd_stall,
      input  o_switch, o_rd_addr, o_rd_vld, o_frame_start, o_frame_done,
             o_busy, o_drop_cnt
   );
endinterface

// File: rtl/pp_rd_addr_gen.sv
// -----------------------------------------------------------------------------
// pp_rd_addr_gen
// Linear read-address counter for one bank of the ping-pong buffer.
//   clk, rst  clock and asynchronous active-high reset
//   clr       force the address back to 0
//   adv       advance (one accepted read); wraps to 0 after the last address
//   addr      registered read address
//   last      addr is the final word of the bank (DP-1)
// Without adv the address holds, which is how consumer stalls are absorbed.
// -----------------------------------------------------------------------------
module pp_rd_addr_gen
   import pingpong_pkg::*;
#(
   parameter int DP = DP_DEF,
   parameter int AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          adv,
   output logic [AW-1:0] addr,
   output logic          last
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DP - 1);

   logic [AW-1:0] addr_reg;
   logic [AW-1:0] addr_next;

   assign last = (addr_reg == LAST_ADDR);
   assign addr = addr_reg;

   always_comb begin
      addr_next = addr_reg;
      if (clr) begin
         addr_next = '0;
      end else if (adv) begin
         // Wrapping on the last accept leaves the address at 0 between frames.
         addr_next = last ? '0 : addr_reg + AW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg <= '0;
      end else begin
         addr_reg <= addr_next;
      end
   end

endmodule

// File: rtl/pingpong_sched.sv
// -----------------------------------------------------------------------------
// pingpong_sched
// Scheduler for the input ping-pong buffer. Waits for the fill bank to report
// full, flips the bank select, lets the buffer settle for SETTLE_CYC cycles,
// then streams addresses 0..DP-1 of the swapped-out bank to the conv engine.
// Also counts input beats that arrive while the fill bank is full and the
// reader is still busy.
//   i_clk, i_rst  clock, asynchronous active-high reset
//   bus           pingpong_sched_if.master (controls in, buffer/consumer out)
// All outputs are registered. i_en low freezes every state element and
// drives the valid/pulse outputs low from the next cycle on. A read is
// accepted only on an enabled edge with o_rd_vld high and no stall.
// -----------------------------------------------------------------------------
module pingpong_sched
   import pingpong_pkg::*;
#(
   parameter int DP         = DP_DEF,
   parameter int AW         = AW_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int DCW        = DCW_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   pingpong_sched_if.master bus
);

   localparam logic [SCW-1:0] SETTLE_LD = SCW'(SETTLE_CYC);

   state_t         state_reg, state_next;
   logic [SCW-1:0] settle_reg, settle_next;
   logic           switch_reg, switch_next;
   logic           rd_vld_reg, rd_vld_next;
   logic           frame_start_reg, frame_start_next;
   logic           frame_done_reg, frame_done_next;
   logic           busy_reg, busy_next;
   logic [DCW-1:0] drop_reg, drop_next;

   logic           accept;
   logic           addr_clr;
   logic           last;
   logic [AW-1:0]  addr;

   assign accept = bus.i_en & rd_vld_reg & ~bus.i_rd_stall & (state_reg == READ);

   pp_rd_addr_gen #(
      .DP (DP),
      .AW (AW)
   ) u_addr (
      .clk  (i_clk),
      .rst  (i_rst),
      .clr  (addr_clr),
      .adv  (accept),
      .addr (addr),
      .last (last)
   );

   always_comb begin
      state_next       = state_reg;
      settle_next      = settle_reg;
      switch_next      = switch_reg;
      rd_vld_next      = 1'b0;
      frame_start_next = 1'b0;
      frame_done_next  = 1'b0;
      addr_clr         = 1'b0;
      drop_next        = drop_reg;

      if (bus.i_en) begin
         case (state_reg)
            WAIT_FILL: begin
               // The only place the bank select may change.
               if (bus.i_fill_ready) begin
                  switch_next = ~switch_reg;
                  settle_next = SETTLE_LD;
                  state_next  = SETTLE;
                  addr_clr    = 1'b1;
               end
            end
            SETTLE: begin
               // Counter value 1 is the last idle cycle; reads start next.
               if (settle_reg <= SCW'(1)) begin
                  settle_next      = '0;
                  state_next       = READ;
                  rd_vld_next      = 1'b1;
                  frame_start_next = 1'b1;
               end else begin
                  settle_next = settle_reg - SCW'(1);
               end
            end
            READ: begin
               if (accept && last) begin
                  state_next      = WAIT_FILL;
                  frame_done_next = 1'b1;
               end else begin
                  // Covers stalls and the first cycle after an i_en freeze.
                  rd_vld_next = 1'b1;
               end
            end
            default: begin
               state_next = WAIT_FILL;
            end
         endcase

         // Fill bank full while the reader still owns the other bank: beat lost.
         if (bus.i_din_vld && bus.i_fill_ready && (state_reg != WAIT_FILL) &&
             (drop_reg != {DCW{1'b1}})) begin
            drop_next = drop_reg + DCW'(1);
         end
      end

      busy_next = (state_next != WAIT_FILL);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg       <= WAIT_FILL;
         settle_reg      <= '0;
         switch_reg      <= 1'b0;
         rd_vld_reg      <= 1'b0;
         frame_start_reg <= 1'b0;
         frame_done_reg  <= 1'b0;
         busy_reg        <= 1'b0;
         drop_reg        <= '0;
      end else begin
         state_reg       <= state_next;
         settle_reg      <= settle_next;
         switch_reg      <= switch_next;
         rd_vld_reg      <= rd_vld_next;
         frame_start_reg <= frame_start_next;
         frame_done_reg  <= frame_done_next;
         busy_reg        <= busy_next;
         drop_reg        <= drop_next;
      end
   end

   assign bus.o_switch      = switch_reg;
   assign bus.o_rd_addr     = addr;
   assign bus.o_rd_vld      = rd_vld_reg;
   assign bus.o_frame_start = frame_start_reg;
   assign bus.o_frame_done  = frame_done_reg;
   assign bus.o_busy        = busy_reg;
   assign bus.o_drop_cnt    = drop_reg;

endmodule

// File: tb/tb_pingpong_sched.sv
// -----------------------------------------------------------------------------
// tb_pingpong_sched
// Self-checking bench for pingpong_sched with DP=8, SETTLE_CYC=2, DCW=4.
// A behavioural model (frame position, remaining settle cycles, drop total)
// is stepped on every rising edge and all outputs are compared against it on
// every falling edge. Directed scenarios add literal expectations, followed
// by a randomized run. One line is printed per completed frame.
// -----------------------------------------------------------------------------
module tb_pingpong_sched;

   localparam int DP         = 8;
   localparam int AW         = 16;
   localparam int SETTLE_CYC = 2;
   localparam int DCW        = 4;
   localparam int DROP_MAX   = (1 << DCW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pingpong_sched_if #(.AW(AW), .DCW(DCW)) bus();

   pingpong_sched #(
      .DP         (DP),
      .AW         (AW),
      .SETTLE_CYC (SETTLE_CYC),
      .DCW        (DCW)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_bad  = 0;
   int cyc    = 0;
   int frames = 0;

   // Model: reading a frame, cycles of settling still to go, position in frame.
   bit m_reading;
   int m_left;
   int m_addr;
   bit m_sw, m_vld, m_fs, m_fd;
   int m_drop;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %0d, want %0d", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_reading = 0; m_left = 0; m_addr = 0;
      m_sw = 0; m_vld = 0; m_fs = 0; m_fd = 0; m_drop = 0;
   endtask

   task automatic model_step();
      bit busy_now;
      if (rst) begin
         model_reset();
      end else if (!bus.i_en) begin
         m_vld = 0; m_fs = 0; m_fd = 0;
      end else begin
         busy_now = m_reading || (m_left > 0);
         if (bus.i_din_vld && bus.i_fill_ready && busy_now && m_drop < DROP_MAX)
            m_drop++;
         m_fs = 0; m_fd = 0;
         if (m_reading) begin
            if (m_vld && !bus.i_rd_stall) begin
               if (m_addr == DP - 1) begin
                  m_reading = 0; m_vld = 0; m_fd = 1; m_addr = 0;
               end else begin
                  m_addr++;
               end
            end else begin
               m_vld = 1;
            end
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_reading = 1; m_vld = 1; m_fs = 1; m_addr = 0;
            end
         end else if (bus.i_fill_ready) begin
            m_sw = !m_sw;
            m_left = SETTLE_CYC;
         end
      end
   endtask

   task automatic compare_all();
      chk("switch",      int'(bus.o_switch),      int'(m_sw));
      chk("rd_addr",     int'(bus.o_rd_addr),     m_addr);
      chk("rd_vld",      int'(bus.o_rd_vld),      int'(m_vld));
      chk("frame_start", int'(bus.o_frame_start), int'(m_fs));
      chk("frame_done",  int'(bus.o_frame_done),  int'(m_fd));
      chk("busy",        int'(bus.o_busy),        int'(m_reading || m_left > 0));
      chk("drop_cnt",    int'(bus.o_drop_cnt),    m_drop);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      compare_all();
      if (bus.o_frame_done) begin
         frames++;
         $display("frame %0d done at cycle %0d switch=%0d drop_cnt=%0d",
                  frames, cyc, bus.o_switch, bus.o_drop_cnt);
      end
   endtask

   task automatic wait_addr(input int a, input int budget);
      int k = 0;
      while (!(bus.o_rd_vld && int'(bus.o_rd_addr) == a) && k < budget) begin
         tick();
         k++;
      end
      chk("reach_addr", int'(bus.o_rd_vld && int'(bus.o_rd_addr) == a), 1);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!bus.o_frame_done && k < budget) begin
         tick();
         k++;
      end
      chk("reach_frame_done", int'(bus.o_frame_done), 1);
   endtask

   // Single fill pulse from idle, then a full unstalled frame with literal timing.
   task automatic frame_literal(input int sw_exp);
      bus.i_fill_ready = 1'b1;
      tick();
      bus.i_fill_ready = 1'b0;
      chk("lit_switch", int'(bus.o_switch), sw_exp);
      chk("lit_busy",   int'(bus.o_busy), 1);
      chk("lit_idle1",  int'(bus.o_rd_vld), 0);
      tick();
      chk("lit_idle2",  int'(bus.o_rd_vld), 0);
      tick();
      for (int i = 0; i < DP; i++) begin
         chk("lit_addr",  int'(bus.o_rd_addr), i);
         chk("lit_vld",   int'(bus.o_rd_vld), 1);
         chk("lit_start", int'(bus.o_frame_start), (i == 0) ? 1 : 0);
         chk("lit_done0", int'(bus.o_frame_done), 0);
         if (i < DP - 1) tick();
      end
      tick();
      chk("lit_done",     int'(bus.o_frame_done), 1);
      chk("lit_vld_end",  int'(bus.o_rd_vld), 0);
      chk("lit_addr_end", int'(bus.o_rd_addr), 0);
      chk("lit_sw_hold",  int'(bus.o_switch), sw_exp);
   endtask

   initial begin
      bus.i_en = 1'b1;
      bus.i_fill_ready = 1'b0;
      bus.i_din_vld = 1'b0;
      bus.i_rd_stall = 1'b0;
      model_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Idle with no fill: nothing moves.
      repeat (50) tick();
      chk("idle_switch", int'(bus.o_switch), 0);
      chk("idle_busy",   int'(bus.o_busy), 0);
      chk("idle_drop",   int'(bus.o_drop_cnt), 0);

      // Basic frame.
      frame_literal(1);

      // Stall at address 4 for three cycles.
      bus.i_fill_ready = 1'b1;
      tick();
      bus.i_fill_ready = 1'b0;
      chk("s3_switch", int'(bus.o_switch), 0);
      wait_addr(4, 20);
      bus.i_rd_stall = 1'b1;
      repeat (3) begin
         tick();
         chk("s3_hold_addr", int'(bus.o_rd_addr), 4);
         chk("s3_hold_vld",  int'(bus.o_rd_vld), 1);
      end
      bus.i_rd_stall = 1'b0;
      for (int a = 5; a < DP; a++) begin
         tick();
         chk("s3_addr", int'(bus.o_rd_addr), a);
      end
      tick();
      chk("s3_done", int'(bus.o_frame_done), 1);

      // Fill held high, beats throughout READ: 8 drops, switch right after done.
      bus.i_fill_ready = 1'b1;
      tick();
      chk("s4_switch1", int'(bus.o_switch), 1);
      wait_addr(0, 10);
      bus.i_din_vld = 1'b1;
      wait_done(20);
      bus.i_din_vld = 1'b0;
      chk("s4_drop", int'(bus.o_drop_cnt), 8);
      tick();
      chk("s4_switch2", int'(bus.o_switch), 0);
      chk("s4_busy",    int'(bus.o_busy), 1);

      // Keep dropping while stalled: counter saturates.
      bus.i_din_vld = 1'b1;
      bus.i_rd_stall = 1'b1;
      repeat (6) tick();
      chk("s5_drop14", int'(bus.o_drop_cnt), 14);
      repeat (14) tick();
      chk("s5_drop_sat", int'(bus.o_drop_cnt), 15);
      bus.i_din_vld = 1'b0;
      bus.i_fill_ready = 1'b0;
      bus.i_rd_stall = 1'b0;
      wait_done(30);

      // Asynchronous reset mid-frame.
      bus.i_fill_ready = 1'b1;
      tick();
      bus.i_fill_ready = 1'b0;
      wait_addr(5, 20);
      chk("s6_switch_pre", int'(bus.o_switch), 1);
      #2 rst = 1'b1;
      #1;
      chk("s6_async_switch", int'(bus.o_switch), 0);
      chk("s6_async_vld",    int'(bus.o_rd_vld), 0);
      chk("s6_async_busy",   int'(bus.o_busy), 0);
      chk("s6_async_drop",   int'(bus.o_drop_cnt), 0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("s6_no_done", int'(bus.o_frame_done), 0);
      frame_literal(1);

      // Enable freeze at address 3.
      bus.i_fill_ready = 1'b1;
      tick();
      bus.i_fill_ready = 1'b0;
      wait_addr(3, 20);
      bus.i_en = 1'b0;
      bus.i_fill_ready = 1'b1;
      repeat (10) begin
         tick();
         chk("s7_freeze_addr", int'(bus.o_rd_addr), 3);
         chk("s7_freeze_vld",  int'(bus.o_rd_vld), 0);
      end
      bus.i_fill_ready = 1'b0;
      bus.i_en = 1'b1;
      tick();
      chk("s7_resume_addr", int'(bus.o_rd_addr), 3);
      chk("s7_resume_vld",  int'(bus.o_rd_vld), 1);
      tick();
      chk("s7_next_addr", int'(bus.o_rd_addr), 4);
      wait_done(20);

      // Randomized traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         bus.i_en         = ($urandom % 8) != 0;
         bus.i_fill_ready = ($urandom % 4) == 0;
         bus.i_din_vld    = ($urandom % 2) == 0;
         bus.i_rd_stall   = ($urandom % 4) == 0;
         rst              = ($urandom % 400) == 0;
         tick();
      end
      rst = 1'b0;
      bus.i_en = 1'b1;
      bus.i_fill_ready = 1'b0;
      bus.i_din_vld = 1'b0;
      bus.i_rd_stall = 1'b0;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
